// File: rtl/core_wb_mem_bridge.sv
// ---------------------------------------------------------------------------
// core_wb_mem_bridge
//
// Bridges a core-native memory port (chip-enable request, rvalid response)
// onto a Wishbone classic master port. Requests are buffered in a small FIFO
// so the core sees backpressure only when the queue is full. Each queued
// request is issued as one classic cycle. The cycle ends on ack, err or a
// bus timeout, and a single-cycle response strobe reports the result.
//
// Optional build macro: BRIDGE_WRITE_RESP_EN
//   defined   - writes also return an rsp_rvalid_o pulse (rdata 0, err flag)
//   undefined - writes complete silently; only reads produce a response
// ---------------------------------------------------------------------------
module core_wb_mem_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REQ_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,

    // Core-native request side
    input  logic                    req_ce_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [DATA_WIDTH/8-1:0] req_sel_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,

    // Core-native response side
    output logic                    rsp_rvalid_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,

    // Wishbone classic master
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i
);

    // -----------------------------------------------------------------------
    // Derived sizes and constants
    // -----------------------------------------------------------------------
    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int PTR_W = $clog2(REQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit so
    // the disabled (0) configuration still elaborates cleanly.
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(REQ_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

`ifdef BRIDGE_WRITE_RESP_EN
    localparam bit WRITE_RESP = 1'b1;
`else
    localparam bit WRITE_RESP = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Request FIFO
    // -----------------------------------------------------------------------
    typedef struct packed {
        logic                  we;
        logic [SEL_W-1:0]      sel;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    req_t              fifo_mem [REQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    req_t              head;
    logic              push;
    logic              pop;

    state_t            state;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_hit;
    logic              bus_done;
    logic              rsp_fire;

    // A push needs the registered ready; a pop happens on the BUS exit edge.
    assign push = req_ce_i && req_ready_o;
    assign pop  = bus_done;
    assign head = fifo_mem[rd_ptr];

    // Occupancy after this edge; simultaneous push and pop cancel out.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_ONE;
        end else if (!push && pop) begin
            count_next = count - CNT_ONE;
        end
    end

    // Request storage is written on push only.
    always_ff @(posedge sys_clk) begin
        // NOTE: the storage array carries no reset; an entry is only ever read
        // after it has been written, and the pointers/count (which are reset)
        // decide which entries are live.
        if (push) begin
            fifo_mem[wr_ptr] <= '{we: req_we_i, sel: req_sel_i, addr: req_addr_i, wdata: req_wdata_i};
        end
    end

    // Pointer, occupancy and registered ready bookkeeping.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        // NOTE: all clocked state uses non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            req_ready_o <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count       <= count_next;
            // Ready reflects the post-edge occupancy, so a full FIFO refuses
            // a push even in the cycle a pop frees a slot.
            req_ready_o <= (count_next < DEPTH_C);
        end
    end

    // -----------------------------------------------------------------------
    // Bus sequencing
    // -----------------------------------------------------------------------
    assign tmo_hit  = TMO_EN && (tmo_cnt == TMO_LAST);
    assign bus_done = (state == BUS) && (wb_ack_i || wb_err_i || tmo_hit);

    // Reads always answer; writes answer only in the write-response build.
    assign rsp_fire = !wb_we_o || WRITE_RESP;

    // IDLE/BUS controller with registered Wishbone outputs and response.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_sel_o     <= '0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            tmo_cnt      <= '0;
            rsp_rvalid_o <= 1'b0;
            rsp_rdata_o  <= '0;
            rsp_err_o    <= 1'b0;
        end else begin
            // Response strobe is a single-cycle pulse by default.
            rsp_rvalid_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (count != '0) begin
                        wb_we_o  <= head.we;
                        wb_sel_o <= head.sel;
                        wb_adr_o <= head.addr;
                        wb_dat_o <= head.wdata;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= BUS;
                    end
                end

                BUS: begin
                    if (bus_done) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        state    <= IDLE;
                        if (rsp_fire) begin
                            rsp_rvalid_o <= 1'b1;
                            // Ack wins over err and timeout; data only
                            // travels back on a successful read.
                            rsp_rdata_o  <= (wb_ack_i && !wb_we_o) ? wb_dat_i : '0;
                            rsp_err_o    <= !wb_ack_i;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/core_wb_mem_bridge.md
Name: core_wb_mem_bridge

Overview:
- Bridges a core-native memory port (chip-enable request, rvalid response) to a Wishbone classic master port.
- Generalised successor of the fixed 32-bit direct ROM/RAM hookup in processorci_top: parametrised data/address width, a buffered request FIFO with backpressure, a bus timeout and error reporting.
- Sits between a core's instruction or data port and the Controller's core/data_mem Wishbone inputs. One instance per port.

Parameters:
- DATA_WIDTH, 32, data bus width; multiple of 8; SEL width = DATA_WIDTH/8.
- ADDR_WIDTH, 32, address width, passed through unmodified.
- REQ_DEPTH, 4, request FIFO depth; power of 2, at least 2.
- TIMEOUT_CYCLES, 256, maximum cycles in BUS without ack/err before forced error; 0 disables timeout.

Ports:
- sys_clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_ce_i  in  1  request valid.
- req_ready_o  out  1  FIFO can accept a request.
- req_we_i  in  1  1 = write.
- req_sel_i  in  DATA_WIDTH/8  byte enables.
- req_addr_i  in  ADDR_WIDTH  address.
- req_wdata_i  in  DATA_WIDTH  write data.
- rsp_rvalid_o  out  1  one-cycle response strobe.
- rsp_rdata_o  out  DATA_WIDTH  read data; valid with rsp_rvalid_o.
- rsp_err_o  out  1  response is an error (wb_err_i or timeout).
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls.
- wb_sel_o  out  DATA_WIDTH/8  Wishbone byte select.
- wb_adr_o  out  ADDR_WIDTH  Wishbone address.
- wb_dat_o  out  DATA_WIDTH  Wishbone write data.
- wb_dat_i  in  DATA_WIDTH  Wishbone read data.
- wb_ack_i, wb_err_i  in  1 each  Wishbone termination.

Behaviour:
- Reset: all outputs 0 except req_ready_o = 1 once reset is released. FIFO empty, FSM in IDLE, timeout counter 0. Asserting rst_n low mid-transaction drops wb_cyc_o/wb_stb_o immediately (asynchronous). The in-flight request is discarded with no response.
- Accept: a request is pushed when req_ce_i && req_ready_o at a rising edge. req_ready_o = (count < REQ_DEPTH), registered. No same-cycle bypass when full, even if a pop occurs that cycle.
- FSM states IDLE and BUS. All Wishbone outputs are registered.
  - IDLE: if the FIFO is non-empty, load wb_* from the FIFO head, set cyc = stb = 1, clear the timeout counter, go to BUS.
  - BUS: hold all wb_* outputs stable.
    - On wb_ack_i or wb_err_i: clear cyc/stb, pop the FIFO, go to IDLE.
    - Else, if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: same exit as above, flagged as timeout.
    - Else: increment the counter.
- Termination priority: ack > err > timeout when more than one is true in the same cycle.
- Response: on the exit edge from BUS, rsp_rvalid_o = 1 for exactly one cycle.
  - rsp_rdata_o = wb_dat_i on a read ack, else 0.
  - rsp_err_o = 1 for err or timeout, 0 for ack.
  - Write responses are governed by the optional feature below.
- Latency (zero-wait slave): request accepted at edge N; wb_cyc_o high from edge N+1; ack sampled at edge N+2; rsp_rvalid_o high from edge N+2 to N+3.
- Throughput: at least one idle cycle with cyc low between transactions, giving 1 transfer per 2 cycles.
- Ordering: strict FIFO; responses return in request order.
- FIFO pointers are log2(REQ_DEPTH)-bit and wrap naturally. Count is log2(REQ_DEPTH)+1 bits. Simultaneous push and pop leaves count unchanged.
- rsp_rdata_o and rsp_err_o hold their last value when rsp_rvalid_o = 0.

Optional Feature:
- Macro: BRIDGE_WRITE_RESP_EN.
- Defined: writes also produce an rsp_rvalid_o pulse on termination, with rsp_rdata_o = 0 and rsp_err_o reflecting err/timeout.
- Undefined: writes produce no response pulse. Write errors are silently dropped; reads behave identically in both builds.

Test Plan:
- Read, zero-wait slave returning 32'hDEADBEEF at addr 32'h0000_0010 → cyc high 1 cycle after accept; rsp_rvalid_o pulse 2 cycles after accept with rdata 32'hDEADBEEF, err 0.
- Back-to-back: 6 reads with the slave stalling ack 3 cycles and REQ_DEPTH=4 → req_ready_o low after 4 accepts; all 6 responses return in order; cyc low at least 1 cycle between transactions.
- Timeout: TIMEOUT_CYCLES=8, slave never acks → cyc high exactly 8 cycles, then rsp_rvalid_o with err 1 and rdata 0; the next queued request proceeds normally.
- wb_err_i and wb_ack_i asserted together on a read → ack wins: err 0, data returned. wb_err_i alone → err 1.
- Write sel 4'b0011, data 32'h1234_5678 → wb_we_o=1, wb_sel_o=4'b0011, wb_dat_o stable until ack. Response pulse present only with BRIDGE_WRITE_RESP_EN.
- rst_n pulled low while in BUS with 2 entries queued → cyc/stb 0 immediately; after release, FIFO is empty, req_ready_o=1, no spurious response.
